spi_mem_slave: RTL and testbench
================================

SPI_MEM_SLAVE -- requirements
Module: spi_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=2).
REQ-002 SHALL have parameter ADDR_W, default 7, address width; memory depth 2^ADDR_W words.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flip-flop stages on each SPI input (>=2).
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge; one clock domain.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-007 SHALL have port cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-008 SHALL have port mosi  input  1  SPI serial data in, asynchronous.
REQ-009 SHALL have port miso  output  1  SPI serial data out.
REQ-010 SHALL have port miso_oe  output  1  MISO pad output enable.
REQ-011 SHALL have port busy  output  1  high while a transaction is active.
REQ-012 SHALL have port wr_strobe  output  1  one-clk pulse per memory write.
REQ-013 SHALL have port frame_err  output  1  one-clk pulse on abort with a partial data frame.

Function
REQ-014 SHALL pass sclk, cs_n, mosi through SYNC_STAGES synchronisers, then detect sclk rise/fall and cs_n fall/rise as one-clk pulses.
REQ-015 SHALL operate in SPI mode 0: sample mosi on sclk rise; update miso on sclk fall; sclk high/low phases >= SYNC_STAGES+3 clk each.
REQ-016 SHALL shift data MSB first.
REQ-017 Header frame SHALL be ADDR_W address bits then one R/W bit (1 = read, 0 = write), ADDR_W+1 bits total.
REQ-018 FSM states SHALL be IDLE, HDR, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_STORE.
REQ-019 IDLE -> HDR on cs_n fall; bit counter and shift register cleared; busy=1.
REQ-020 HDR: on the (ADDR_W+1)th sclk rise, latch address; R/W=1 -> RD_LOAD, else WR_SHIFT.
REQ-021 RD_LOAD: synchronous memory read at current address (1 clk latency), load shift register, -> RD_SHIFT; completes before next sclk fall.
REQ-022 RD_SHIFT: miso_oe=1 from first sclk fall after header; each sclk fall drives next bit; after DATA_W sclk rises, address+1, -> RD_LOAD (burst prefetch).
REQ-023 WR_SHIFT: after DATA_W sclk rises, -> WR_STORE.
REQ-024 WR_STORE: write word to mem[address], wr_strobe=1 for exactly one clk, address+1, -> WR_SHIFT.
REQ-025 Address increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-026 Burst length SHALL be unbounded; each full DATA_W frame is one word.
REQ-027 cs_n rise in any state SHALL go to IDLE next clk: miso_oe=0, busy=0, miso=0.
REQ-028 cs_n rise with 1..DATA_W-1 data bits received SHALL discard the word (no write) and pulse frame_err once; partial header aborts silently.
REQ-029 cs_n rise coincident with a completed write frame SHALL still perform that write before IDLE.
REQ-030 miso SHALL be 0 whenever miso_oe=0.
REQ-031 Memory SHALL be 2^ADDR_W x DATA_W, single port, internal.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE, miso=0, miso_oe=0, busy=0, wr_strobe=0, frame_err=0, counters/address/shift register 0, synchroniser flops to idle levels (sclk=0, cs_n=1, mosi=0).
REQ-033 Memory contents SHALL NOT be affected by reset.
REQ-034 After reset release, a transaction SHALL start only on a fresh cs_n fall; cs_n already low SHALL be ignored until it rises and falls.

Verification
REQ-035 Write: DATA_W=8, ADDR_W=7; header 0x24 (addr 0x12, W), data 0xA5 -> one wr_strobe pulse; mem[0x12]=0xA5; frame_err=0.
REQ-036 Read: header 0x25, 8 sclk -> miso shifts 1,0,1,0,0,1,0,1; miso_oe=1 during data, 0 after cs_n rise.
REQ-037 Burst wrap: header 0xFE, data 0x11,0x22,0x33 -> mem[0x7F]=0x11, mem[0x00]=0x22, mem[0x01]=0x33; three wr_strobe pulses; then read burst from 0x7F returns 0x11,0x22.
REQ-038 Abort: write header 0x30, 5 data bits, cs_n rise -> no wr_strobe, one frame_err pulse, mem[0x18] unchanged, busy=0 next clk.
REQ-039 Reset mid-read: reset during RD_SHIFT bit 3 -> miso=0, miso_oe=0, busy=0 immediately (before next clk edge); held-low cs_n ignored until re-asserted.
REQ-040 Parameter sweep: DATA_W=16, ADDR_W=4: header 0x1E (addr 0xF, W), data 0xBEEF, 0x1234 -> mem[0xF]=0xBEEF, mem[0x0]=0x1234.

Source files
------------

// File: rtl/spi_mem_slave.sv
// SPI mode-0 memory slave: a header of ADDR_W address bits plus an R/W bit
// opens an auto-incrementing burst into an internal single-port memory.
// All SPI pins are synchronised into the clk domain and edge-detected there.
module spi_mem_slave #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic wr_strobe,
  output logic frame_err
);

  // The R/W bit is consumed live, so the shifter only has to hold ADDR_W
  // header bits or one full data word.
  localparam int SH_W  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, HDR, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_STORE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] vld_pipe_q, vld_pipe_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   armed_q, armed_d;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SH_W-1:0]        sh_q, sh_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   ferr_q, ferr_d;
  logic                   stop_q, stop_d;

  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DATA_W-1:0]      rd_data;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic wr_done;

  // Synchroniser shift, edge history and arming after reset.
  // vld_pipe tracks when the reset values have been flushed out of the
  // chains; armed only rises once a genuine high cs_n has been seen, so a
  // cs_n already low at reset release never opens a transaction.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    vld_pipe_d  = {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    armed_d     = armed_q | (vld_pipe_q[SYNC_STAGES-1] & cs_s);
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    cs_fall     = armed_q & cs_prev_q & ~cs_s;
    cs_rise     = cs_s & ~cs_prev_q;
  end

  // Next-state and datapath: header decode, read prefetch, write collect.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    miso_oe_d = miso_oe_q;
    ferr_d    = 1'b0;
    stop_d    = stop_q;
    wr_done   = (state_q == WR_SHIFT) && sclk_rise && (cnt_q == CNT_W'(DATA_W - 1));
    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        stop_d    = 1'b0;
        if (cs_fall) begin
          state_d = HDR;
          cnt_d   = '0;
          sh_d    = '0;
        end
      end
      HDR: begin
        if (sclk_rise) begin
          sh_d = {sh_q[SH_W-2:0], mosi_s};
          if (cnt_q == CNT_W'(ADDR_W)) begin
            cnt_d   = '0;
            addr_d  = sh_q[ADDR_W-1:0];
            state_d = mosi_s ? RD_LOAD : WR_SHIFT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RD_LOAD: begin
        // rd_data was fetched from addr_d on the edge that entered here
        sh_d    = SH_W'(rd_data);
        state_d = RD_SHIFT;
      end
      RD_SHIFT: begin
        if (sclk_fall) begin
          miso_d    = sh_q[DATA_W-1];
          miso_oe_d = 1'b1;
          sh_d      = sh_q << 1;
        end
        if (sclk_rise) begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            addr_d  = addr_q + 1'b1;
            state_d = RD_LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR_SHIFT: begin
        if (sclk_rise) begin
          sh_d = {sh_q[SH_W-2:0], mosi_s};
          if (wr_done) begin
            cnt_d   = '0;
            state_d = WR_STORE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR_STORE: begin
        addr_d  = addr_q + 1'b1;
        state_d = stop_q ? IDLE : WR_SHIFT;
      end
      default: state_d = IDLE;
    endcase
    // Deselect wins everywhere, except that a word completed on the same
    // clk is still committed through WR_STORE before going idle.
    if (cs_rise && (state_q != IDLE)) begin
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      if (wr_done) begin
        stop_d = 1'b1;
      end else begin
        state_d = IDLE;
        if ((state_q == WR_SHIFT) && ((cnt_q != '0) || sclk_rise))
          ferr_d = 1'b1;
      end
    end
  end

  // State and synchroniser registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_pipe_q  <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      ferr_q      <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      vld_pipe_q  <= vld_pipe_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      ferr_q      <= ferr_d;
      stop_q      <= stop_d;
    end
  end

  // Single-port memory, deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (state_q == WR_STORE)
      mem[addr_q] <= sh_q[DATA_W-1:0];
    rd_data <= mem[addr_d];
  end

  assign miso      = miso_q & miso_oe_q;
  assign miso_oe   = miso_oe_q;
  assign busy      = (state_q != IDLE);
  assign wr_strobe = (state_q == WR_STORE);
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// Bench for spi_mem_slave: two instances (8x128 and 16x16) share sclk/mosi
// and have separate chip selects. A plain array model tracks memory
// contents; reads are compared word by word against it.
module tb_spi_mem_slave;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0, mosi = 1'b0, cs_a = 1'b1, cs_b = 1'b1;
  logic miso_a, oe_a, busy_a, wr_a, ferr_a;
  logic miso_b, oe_b, busy_b, wr_b, ferr_b;

  int total = 0, bad = 0;
  int wr_cnt_a = 0, ferr_cnt_a = 0, busy_cnt_a = 0, wr_cnt_b = 0, ferr_cnt_b = 0;
  logic [7:0]  mem_a [128];
  logic [15:0] mem_b [16];
  logic [15:0] wq [$];

  always #5 clk = ~clk;

  spi_mem_slave #(.DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_a), .mosi(mosi),
    .miso(miso_a), .miso_oe(oe_a), .busy(busy_a), .wr_strobe(wr_a), .frame_err(ferr_a));

  spi_mem_slave #(.DATA_W(16), .ADDR_W(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_b), .mosi(mosi),
    .miso(miso_b), .miso_oe(oe_b), .busy(busy_b), .wr_strobe(wr_b), .frame_err(ferr_b));

  always @(posedge clk) begin
    if (wr_a)   wr_cnt_a   <= wr_cnt_a + 1;
    if (ferr_a) ferr_cnt_a <= ferr_cnt_a + 1;
    if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
    if (wr_b)   wr_cnt_b   <= wr_cnt_b + 1;
    if (ferr_b) ferr_cnt_b <= ferr_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dw(input int sel); return (sel != 0) ? 16 : 8; endfunction
  function automatic int aw(input int sel); return (sel != 0) ? 4 : 7; endfunction

  task automatic set_cs(input int sel, input logic v);
    if (sel != 0) cs_b = v; else cs_a = v;
  endtask

  // One mode-0 bit: data set while sclk low, slave output sampled at the rise.
  task automatic spi_bit(input int sel, input logic b, output logic r, output logic oe);
    mosi = b;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    r  = (sel != 0) ? miso_b : miso_a;
    oe = (sel != 0) ? oe_b : oe_a;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic start(input int sel, input int addr, input logic rw);
    logic r, oe;
    @(negedge clk);
    set_cs(sel, 1'b0);
    repeat (HALF) @(negedge clk);
    for (int i = aw(sel) - 1; i >= 0; i--) spi_bit(sel, addr[i], r, oe);
    spi_bit(sel, rw, r, oe);
  endtask

  task automatic stop(input int sel);
    repeat (HALF) @(negedge clk);
    set_cs(sel, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_write(input int sel, input int addr, input string tag);
    int wr0, fe0, a;
    logic r, oe;
    logic [15:0] w;
    wr0 = (sel != 0) ? wr_cnt_b : wr_cnt_a;
    fe0 = (sel != 0) ? ferr_cnt_b : ferr_cnt_a;
    start(sel, addr, 1'b0);
    for (int k = 0; k < wq.size(); k++) begin
      w = wq[k];
      for (int i = dw(sel) - 1; i >= 0; i--) spi_bit(sel, w[i], r, oe);
      a = (addr + k) % (1 << aw(sel));
      if (sel != 0) mem_b[a] = w; else mem_a[a] = w[7:0];
    end
    stop(sel);
    chk({tag, "_wrcnt"}, ((sel != 0) ? wr_cnt_b : wr_cnt_a) - wr0, wq.size());
    chk({tag, "_ferr"}, ((sel != 0) ? ferr_cnt_b : ferr_cnt_a) - fe0, 0);
    chk({tag, "_busy"}, 32'((sel != 0) ? busy_b : busy_a), 0);
  endtask

  task automatic spi_read(input int sel, input int addr, input int n, input string tag);
    logic r, oe, oe_all;
    logic [15:0] w, exp;
    int a;
    start(sel, addr, 1'b1);
    for (int k = 0; k < n; k++) begin
      w = '0;
      oe_all = 1'b1;
      for (int i = dw(sel) - 1; i >= 0; i--) begin
        spi_bit(sel, 1'($urandom_range(0, 1)), r, oe);
        w[i] = r;
        oe_all = oe_all & oe;
      end
      a = (addr + k) % (1 << aw(sel));
      exp = (sel != 0) ? mem_b[a] : {8'h00, mem_a[a]};
      chk($sformatf("%s_word%0d", tag, k), 32'(w), 32'(exp));
      chk($sformatf("%s_oe%0d", tag, k), 32'(oe_all), 1);
    end
    stop(sel);
    chk({tag, "_oe_off"}, 32'((sel != 0) ? oe_b : oe_a), 0);
    chk({tag, "_miso_off"}, 32'((sel != 0) ? miso_b : miso_a), 0);
    chk({tag, "_busy_off"}, 32'((sel != 0) ? busy_b : busy_a), 0);
  endtask

  initial begin
    logic r, oe;
    logic [7:0] wb;
    int wr0, fe0, bz0, sel, addr, n;

    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso_a), 0);
    chk("rst_oe", 32'(oe_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_wr", 32'(wr_a), 0);
    chk("rst_ferr", 32'(ferr_a), 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // fill both memories so every later read has a known expectation
    wq.delete();
    for (int i = 0; i < 128; i++) wq.push_back(16'($urandom_range(0, 255)));
    spi_write(0, 0, "init_a");
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(16'($urandom_range(0, 65535)));
    spi_write(1, 0, "init_b");

    // single write then read of 0x12
    wq.delete(); wq.push_back(16'h00A5);
    spi_write(0, 'h12, "wr12");
    spi_read(0, 'h12, 1, "rd12");

    // burst across the top of the address space
    wq.delete(); wq.push_back(16'h0011); wq.push_back(16'h0022); wq.push_back(16'h0033);
    spi_write(0, 'h7F, "wrap");
    spi_read(0, 'h7F, 2, "wrap_rd");
    spi_read(0, 'h00, 2, "wrap_rd0");

    // partial data frame abort
    wq.delete(); wq.push_back(16'h005C);
    spi_write(0, 'h18, "pre18");
    wr0 = wr_cnt_a; fe0 = ferr_cnt_a;
    start(0, 'h18, 1'b0);
    for (int i = 0; i < 5; i++) spi_bit(0, 1'($urandom_range(0, 1)), r, oe);
    repeat (HALF) @(negedge clk);
    chk("abort_busy_pre", 32'(busy_a), 1);
    cs_a = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_wr", wr_cnt_a - wr0, 0);
    chk("abort_ferr", ferr_cnt_a - fe0, 1);
    chk("abort_busy", 32'(busy_a), 0);
    spi_read(0, 'h18, 1, "abort_rd");

    // deselect on the same clk as the last data rise still commits the word
    wr0 = wr_cnt_a; fe0 = ferr_cnt_a;
    wb = 8'($urandom_range(0, 255));
    start(0, 'h40, 1'b0);
    for (int i = 7; i >= 1; i--) spi_bit(0, wb[i], r, oe);
    mosi = wb[0];
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    cs_a = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    mem_a['h40] = wb;
    chk("coin_wr", wr_cnt_a - wr0, 1);
    chk("coin_ferr", ferr_cnt_a - fe0, 0);
    spi_read(0, 'h40, 1, "coin_rd");

    // reset in the middle of a read, cs_n held low across it
    start(0, 'h12, 1'b1);
    for (int i = 0; i < 3; i++) spi_bit(0, 1'b0, r, oe);
    chk("mid_oe", 32'(oe_a), 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_miso", 32'(miso_a), 0);
    chk("mid_rst_oe", 32'(oe_a), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    wr0 = wr_cnt_a; bz0 = busy_cnt_a;
    for (int i = 0; i < 16; i++) spi_bit(0, 1'($urandom_range(0, 1)), r, oe);
    chk("held_cs_busy", busy_cnt_a - bz0, 0);
    chk("held_cs_wr", wr_cnt_a - wr0, 0);
    chk("held_cs_oe", 32'(oe_a), 0);
    cs_a = 1'b1;
    repeat (6) @(negedge clk);
    spi_read(0, 'h12, 1, "post_rst");

    // 16-bit / 4-bit address instance, burst wrapping 0xF -> 0x0
    wq.delete(); wq.push_back(16'hBEEF); wq.push_back(16'h1234);
    spi_write(1, 'hF, "b_wrap");
    spi_read(1, 'hF, 2, "b_rd");

    // randomized bursts on both instances
    for (int t = 0; t < 6; t++) begin
      sel = $urandom_range(0, 1);
      addr = $urandom_range(0, (1 << aw(sel)) - 1);
      n = $urandom_range(1, 4);
      wq.delete();
      for (int k = 0; k < n; k++)
        wq.push_back(16'($urandom_range(0, (1 << dw(sel)) - 1)));
      spi_write(sel, addr, $sformatf("rnd%0d", t));
      spi_read(sel, addr, n, $sformatf("rnd%0d_back", t));
      spi_read(sel, $urandom_range(0, (1 << aw(sel)) - 1), $urandom_range(1, 4),
               $sformatf("rnd%0d_any", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
